// File: rtl/int_to_floating_point.sv
// int_to_floating_point
//   Multi-cycle signed-integer to IEEE-754 single-precision converter.
//   The operand magnitude is normalised by a one-bit-per-cycle left shift loop,
//   then rounded in a single cycle using the 2-bit FPU rounding-mode encoding
//   (00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even).
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset, aborts any conversion
//   i_start        request, sampled only while idle
//   i_int          signed two's-complement operand, captured on acceptance
//   i_conv         rounding mode, captured with i_int
//   o_float        packed result, held until the next accepted request
//   o_inexact_flag result differs from the exact integer value
//   o_busy         high whenever a conversion is in flight
//   o_done         one-cycle pulse, result valid from this cycle onward
module int_to_floating_point #(
  parameter int int_size      = 64,
  parameter int mantissa_size = 23,
  parameter int exponent_size = 8,
  parameter int precision     = 32,
  parameter int exp_bias      = 127
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [int_size-1:0]  i_int,
  input  logic [1:0]           i_conv,
  output logic [precision-1:0] o_float,
  output logic                 o_inexact_flag,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(int_size);
  // Index of the guard bit once the leading one sits at the MSB.
  localparam int GB = int_size - 2 - mantissa_size;
  localparam logic [exponent_size-1:0] EXP_TOP = exponent_size'(exp_bias + int_size - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  logic [1:0]           r_state;
  logic [int_size-1:0]  r_mag;
  logic [CW-1:0]        r_count;
  logic                 r_sign;
  logic [1:0]           r_conv;
  logic                 r_zero;
  logic [precision-1:0] r_float;
  logic                 r_inexact;
  logic                 r_done;

  logic [int_size-1:0]      w_abs;
  logic [mantissa_size-1:0] w_frac;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_up;
  logic [mantissa_size:0]   w_msum;
  logic [exponent_size-1:0] w_exp;

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  assign w_abs = i_int[int_size-1] ? ((~i_int) + int_size'(1)) : i_int;

  assign w_frac   = r_mag[int_size-2 -: mantissa_size];
  assign w_guard  = r_mag[GB];
  // Shifting the guard bit and everything above it out leaves only the sticky bits.
  assign w_sticky = |(r_mag << (int_size - GB));

  always_comb begin
    w_up = 1'b0;
    case (r_conv)
      2'b00: w_up = 1'b0;
      2'b01: w_up = (w_guard | w_sticky) & ~r_sign;
      2'b10: w_up = (w_guard | w_sticky) & r_sign;
      2'b11: w_up = w_guard & (w_sticky | w_frac[0]);
      default: w_up = 1'b0;
    endcase
  end

  // A carry out of the fraction leaves the low bits at zero and bumps the exponent.
  assign w_msum = {1'b0, w_frac} + {{mantissa_size{1'b0}}, w_up};
  assign w_exp  = EXP_TOP - exponent_size'(r_count) + exponent_size'(w_msum[mantissa_size]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_mag     <= '0;
      r_count   <= '0;
      r_sign    <= 1'b0;
      r_conv    <= '0;
      r_zero    <= 1'b0;
      r_float   <= '0;
      r_inexact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sign  <= i_int[int_size-1];
            r_mag   <= w_abs;
            r_conv  <= i_conv;
            r_count <= '0;
            r_zero  <= 1'b0;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_mag == '0) begin
            r_zero  <= 1'b1;
            r_state <= S_ROUND;
          end else if (r_mag[int_size-1]) begin
            r_state <= S_ROUND;
          end else begin
            r_mag   <= r_mag << 1;
            r_count <= r_count + CW'(1);
          end
        end
        S_ROUND: begin
          if (r_zero) begin
            r_float   <= '0;
            r_inexact <= 1'b0;
          end else begin
            r_float   <= {r_sign, w_exp, w_msum[mantissa_size-1:0]};
            r_inexact <= w_guard | w_sticky;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_float        = r_float;
  assign o_inexact_flag = r_inexact;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;

endmodule

// File: tb/tb_int_to_floating_point.sv
// Testbench for int_to_floating_point: directed vectors with hand-computed
// results pushed to a scoreboard queue; a negedge monitor pops and checks
// result, inexact flag and latency on every done pulse.
module tb_int_to_floating_point;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] din;
  logic [1:0]  conv;
  logic [31:0] flt;
  logic        inexact;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] f;
    logic        inx;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;

  int_to_floating_point #(
    .int_size(64), .mantissa_size(23), .exponent_size(8), .precision(32), .exp_bias(127)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_int(din), .i_conv(conv),
    .o_float(flt), .o_inexact_flag(inexact), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("float", {32'd0, flt}, {32'd0, e.f});
        chk("inexact", {63'd0, inexact}, {63'd0, e.inx});
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) chk("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  // lat counts the accepting cycle as cycle 1; expected lz + 3.
  task automatic run(input logic [63:0] v, input logic [1:0] c,
                     input logic [31:0] ef, input logic ei, input int lat);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start = 1'b1; din = v; conv = c;
    @(posedge clk); #1;
    start = 1'b0;
    e.f = ef; e.inx = ei; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
    din  = ~v;
    conv = ~c;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   acc1;
    int   k;
    int   dsnap;
    rst = 1'b1; start = 1'b0; din = '0; conv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_float", {32'd0, flt}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Abort a long conversion with reset; no done may follow.
    @(negedge clk); start = 1'b1; din = 64'd1; conv = 2'b00;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    repeat (10) @(negedge clk);
    dsnap = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_float", {32'd0, flt}, 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_done", 64'(n_done - dsnap), 64'd0);

    run(64'd1, 2'b00, 32'h3F800000, 1'b0, 66);
    run(64'hFFFFFFFFFFFFFFFF, 2'b11, 32'hBF800000, 1'b0, 66);
    run(64'd0, 2'b11, 32'h00000000, 1'b0, 3);
    run(64'h8000000000000000, 2'b11, 32'hDF000000, 1'b0, 3);
    run(64'd16777217, 2'b00, 32'h4B800000, 1'b1, 42);
    run(64'd16777217, 2'b01, 32'h4B800001, 1'b1, 42);
    run(64'd16777217, 2'b10, 32'h4B800000, 1'b1, 42);
    run(64'd16777217, 2'b11, 32'h4B800000, 1'b1, 42);
    run(64'd16777219, 2'b11, 32'h4B800002, 1'b1, 42);
    run(64'd33554431, 2'b11, 32'h4C000000, 1'b1, 42);
    run(-64'sd16777217, 2'b10, 32'hCB800001, 1'b1, 42);
    run(-64'sd16777217, 2'b01, 32'hCB800000, 1'b1, 42);
    run(64'd1000, 2'b00, 32'h447A0000, 1'b0, 57);
    run(64'h7FFFFFFFFFFFFFFF, 2'b11, 32'h5F000000, 1'b1, 4);
    run(64'h7FFFFFFFFFFFFFFF, 2'b00, 32'h5EFFFFFF, 1'b1, 4);

    // Start held high: operand changes while busy are ignored, and a second
    // request is accepted in the done cycle of the first.
    wait_idle();
    @(negedge clk); start = 1'b1; din = 64'd5; conv = 2'b11;
    @(posedge clk); #1;
    acc1 = cyc;
    e.f = 32'h40A00000; e.inx = 1'b0; e.acc = acc1; e.lat = 64;
    sb.push_back(e);
    repeat (5) @(posedge clk);
    #1 din = 64'd7;
    e.f = 32'h40E00000; e.inx = 1'b0; e.acc = acc1 + 64; e.lat = 64;
    sb.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 200);
    if (k >= 200) chk("handshake_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("second_accept_busy", {63'd0, busy}, 64'd1);
    din = 64'd123;
    wait_drain();

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("float_held", {32'd0, flt}, 64'h40E00000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_to_floating_point.md
Name: int_to_floating_point

Overview:
- Multi-cycle converter from a signed two's-complement integer to a single-precision IEEE-754 float.
- Sits upstream of the float-to-int stage in the FPU conversion path. It produces packed floats on the same precision/exponent/mantissa parameter set.
- It uses the same 2-bit rounding-mode encoding as the rest of the FPU.
- Normalisation uses a one-bit-per-cycle leading-zero shift loop, followed by a single rounding cycle.

Parameters:
- int_size, 64, width of the signed integer input.
- mantissa_size, 23, stored fraction bits.
- exponent_size, 8, exponent field bits.
- precision, 32, total float width (1 + exponent_size + mantissa_size).
- exp_bias, 127, exponent bias (2^(exponent_size-1) - 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- int  input  int_size  signed two's-complement operand; captured on the accepting edge.
- conv  input  2  rounding mode; captured with int.
  - 00 toward zero.
  - 01 toward +inf.
  - 10 toward -inf.
  - 11 nearest, ties to even.
- float  output  precision  result; held stable until the next accepted start.
- inexact_flag  output  1  result differs from the exact integer value; valid with done.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; float and inexact_flag are valid from this cycle onward.

Behaviour:
- Reset (sync, active-high): state=IDLE; float=0, inexact_flag=0, done=0, busy=0. Internal magnitude, shift count and sign are cleared. Reset asserted in any state aborts the conversion; no done is issued.

States:
- IDLE:
  - If start=1, capture sign=int[msb], magnitude=|int| as an int_size-bit unsigned value, conv, and shift count=0.
  - -2^(int_size-1) gives magnitude 100..0 with no overflow.
  - Go to NORM.
  - If start=0, stay in IDLE.
- NORM, evaluated each edge:
  - magnitude==0: set zero marker and go to ROUND.
  - Else if magnitude[int_size-1]==1: go to ROUND.
  - Else: magnitude <<= 1, count += 1, stay in NORM.
- ROUND, single edge:
  - Fraction m = magnitude[int_size-2 : int_size-1-mantissa_size].
  - Guard g = next lower bit; sticky s = OR of all remaining lower bits.
  - Round-up decision:
    - 00: never.
    - 01: (g|s) & !sign.
    - 10: (g|s) & sign.
    - 11: g & (s | m[0]).
  - If rounding up, m += 1. On carry out of m, m=0 and the exponent increments.
  - Exponent = exp_bias + int_size - 1 - count (+1 on carry).
  - float = {sign, exponent, m}; inexact_flag = g|s.
  - Zero marker set: float=0 (always +0) and inexact_flag=0.
  - done <= 1, then go to IDLE.
- done is high for exactly the first IDLE cycle after ROUND, then 0. float and inexact_flag persist.

Timing and boundary rules:
- Latency from the accepting edge to done high: lz + 3 cycles, where lz = leading zeros of the magnitude (0..int_size-1).
  - Zero input takes 3 cycles.
  - Input 1 takes int_size + 2 cycles.
- start while busy=1 is ignored (not queued); int and conv may change freely once captured.
- A start in the same cycle that done is high is accepted; done still pulses for the previous result.
- With defaults the maximum exponent is 190, so the result never overflows to infinity. NaN, inf and denormal are never produced.
- The sign of a nonzero result always matches the input sign.

Test Plan:
- Reset behaviour:
  - Stimulus: assert reset during NORM of input 1 (about 10 cycles into the 66-cycle conversion).
  - Required: next edge gives busy=0, done=0, float=0x00000000, and no done pulse ever appears.
  - Then start with int=1, conv=00: done after 66 cycles, float=0x3F800000, inexact=0.
- Signs and extremes, conv=11:
  - int=-1 -> 0xBF800000, inexact=0.
  - int=0 -> 0x00000000 in 3 cycles, inexact=0.
  - int=0x8000000000000000 -> 0xDF000000, done 3 cycles after start, inexact=0.
- Rounding modes on int=16777217 (2^24+1):
  - conv=00 -> 0x4B800000.
  - conv=01 -> 0x4B800001.
  - conv=10 -> 0x4B800000.
  - conv=11 (tie to even) -> 0x4B800000.
  - All four cases give inexact=1.
- Ties and carry, conv=11:
  - int=16777219 -> 0x4B800002 (tie rounds up to even).
  - int=33554431 (2^25-1) -> mantissa carry gives 0x4C000000, inexact=1.
  - Negative directed case: int=-16777217, conv=10 -> 0xCB800001.
- Handshake:
  - Hold start=1 continuously with int=5, then change int to 7 while busy.
  - Required: first result 0x40A00000. The second conversion is captured on the cycle done is high, using whatever int is present then (7 -> 0x40E00000).
  - The changes made while busy never corrupt the in-flight result.
